ac97_frame_tx: RTL and testbench

- Serializes one 76-bit AC'97 output word per frame (tag, slot 1, slot 2, slot 3) onto the codec serial link.
- Drives `sync` and `sdata_out` MSB-first; pads each 256-bit frame with 180 zero bits.
- Sits between the audio controller's shifter handshake (`shft_data`/`shft_load`/`shft_ready`) and the codec pins.
- `clk` is the codec bit clock. A one-word holding register decouples loads from frame boundaries.

---
 rtl/ac97_frame_tx_if.sv | 11 +
 rtl/ac97_frame_tx.sv | 143 ++++++++++++++
 tb/tb_ac97_frame_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ac97_frame_tx_if.sv
// Shifter handshake between the audio controller and ac97_frame_tx.
interface ac97_frame_tx_if #(
    parameter int WORD_BITS = 76
);
    logic [WORD_BITS-1:0] shft_data;
    logic                 shft_load;
    logic                 shft_ready;

    modport master (output shft_data, output shft_load, input shft_ready);
    modport slave  (input shft_data, input shft_load, output shft_ready);
endinterface

// File: rtl/ac97_frame_tx.sv
// AC'97 output frame serializer: one 76-bit word per 256-bit frame, MSB first.
// Define AC97_TX_UNDERRUN_REPEAT_EN to resend the last word on underrun.
module ac97_frame_tx #(
    parameter int FRAME_BITS = 256,
    parameter int WORD_BITS  = 76,
    parameter int SYNC_BITS  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    ac97_frame_tx_if.slave shft,
    output logic          sync,
    output logic          sdata_out,
    output logic          frame_start,
    output logic          overflow
);
    localparam int CW = $clog2(FRAME_BITS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] frame_q, frame_d;
    logic [WORD_BITS-1:0] hold_q, hold_d;
    logic                 full_q, full_d;
    logic                 ready_q, ready_d;
    logic                 sync_q, sync_d;
    logic                 sdata_q, sdata_d;
    logic                 fs_q, fs_d;
    logic                 ovf_q, ovf_d;
    logic                 start;
`ifdef AC97_TX_UNDERRUN_REPEAT_EN
    logic [WORD_BITS-1:0] last_q, last_d;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        hold_d    = hold_q;
        full_d    = full_q;
        ovf_d     = ovf_q | (shft.shft_load & full_q);
        sync_d    = 1'b0;
        sdata_d   = 1'b0;
        fs_d      = 1'b0;
        start     = 1'b0;
`ifdef AC97_TX_UNDERRUN_REPEAT_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (bit_cnt_q == CW'(FRAME_BITS - 1)) begin
                    // Enable is only sampled at the frame boundary.
                    if (en) begin
                        start = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        frame_d   = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    frame_d   = frame_q << 1;
                    sync_d    = (bit_cnt_d < CW'(SYNC_BITS));
                    sdata_d   = frame_d[WORD_BITS-1];
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            bit_cnt_d = '0;
            fs_d      = 1'b1;
            sync_d    = 1'b1;
            if (full_q) begin
                frame_d = hold_q;
                full_d  = 1'b0;
`ifdef AC97_TX_UNDERRUN_REPEAT_EN
                last_d  = hold_q;
`endif
            end else begin
`ifdef AC97_TX_UNDERRUN_REPEAT_EN
                frame_d = last_q;
`else
                frame_d = '0;
`endif
            end
            sdata_d = frame_d[WORD_BITS-1];
        end

        // A load coinciding with an underrun latch is kept for the next frame.
        if (shft.shft_load && !full_q) begin
            hold_d = shft.shft_data;
            full_d = 1'b1;
        end
        ready_d = ~full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
            ready_q   <= 1'b1;
            sync_q    <= 1'b0;
            sdata_q   <= 1'b0;
            fs_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            ready_q   <= ready_d;
            sync_q    <= sync_d;
            sdata_q   <= sdata_d;
            fs_q      <= fs_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef AC97_TX_UNDERRUN_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= '0;
        else        last_q <= last_d;
    end
`endif

    assign shft.shft_ready = ready_q;
    assign sync            = sync_q;
    assign sdata_out       = sdata_q;
    assign frame_start     = fs_q;
    assign overflow        = ovf_q;
endmodule

// File: tb/tb_ac97_frame_tx.sv
// Directed bench for ac97_frame_tx: frame content, handshake, underrun, enable drop, reset.
module tb_ac97_frame_tx;
    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic sync, sdata_out, frame_start, overflow;
    int   n_cmp = 0;
    int   n_bad = 0;

    ac97_frame_tx_if bus ();

    ac97_frame_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .shft        (bus.slave),
        .sync        (sync),
        .sdata_out   (sdata_out),
        .frame_start (frame_start),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    localparam logic [75:0] WA = 76'h9000_00000_00000_AB000;
    localparam logic [75:0] WB = 76'hA5C3_12345_6789A_BCDEF;
    localparam logic [75:0] WC = 76'h1234_FFFFF_00000_FFFFF;
    localparam logic [75:0] WD = 76'hF00F_11111_22222_33333;
    localparam logic [75:0] WE = 76'h8888_AAAAA_55555_CCCCC;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples one frame starting at the current bit 0; optional loads / enable drop at bit n.
    task automatic run_frame(input int la, input logic [75:0] da, input int lb,
                             input logic [75:0] db, input int drop,
                             output logic [255:0] d, output logic [255:0] s,
                             output logic [255:0] fs, output logic [255:0] r);
        for (int n = 0; n < 256; n++) begin
            d[255-n]  = sdata_out;
            s[255-n]  = sync;
            fs[255-n] = frame_start;
            r[255-n]  = bus.shft_ready;
            bus.shft_load = (n == la) || (n == lb);
            if (n == la) bus.shft_data = da;
            if (n == lb) bus.shft_data = db;
            if (n == drop) en = 1'b0;
            tick();
        end
        bus.shft_load = 1'b0;
    endtask

    initial begin
        logic [255:0] d, s, fs, r;
        logic [255:0] exp_sync, exp_fs, exp_rdy, exp_under;
        logic [95:0]  rnd;
        logic         seen;

        exp_sync = {16'hFFFF, 240'b0};
        exp_fs   = {1'b1, 255'b0};
        exp_rdy  = {11'h7FF, 245'b0};

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            bus.shft_data = rnd[75:0];
            bus.shft_load = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_ready", 256'(bus.shft_ready), 256'(1));
        chk("rst_sync", 256'(sync), 256'(0));
        chk("rst_sdata", 256'(sdata_out), 256'(0));
        chk("rst_fs", 256'(frame_start), 256'(0));
        chk("rst_ovf", 256'(overflow), 256'(0));
        en = 1'b0;
        bus.shft_load = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single word loaded in IDLE, then enable
        bus.shft_data = WA;
        bus.shft_load = 1'b1;
        tick();
        bus.shft_load = 1'b0;
        chk("load_ready_low", 256'(bus.shft_ready), 256'(0));
        en = 1'b1;
        tick();
        chk("a_bit0_fs", 256'(frame_start), 256'(1));
        chk("a_bit0_sync", 256'(sync), 256'(1));
        chk("a_bit0_sdata", 256'(sdata_out), 256'(1));

        // Frame A with B accepted at bit 10 and C dropped at bit 100
        run_frame(10, WB, 100, WC, -1, d, s, fs, r);
        chk("a_data", d, {WA, 180'b0});
        chk("a_slot3_hi", 256'(d[199:192]), 256'(8'hAB));
        chk("a_sync", s, exp_sync);
        chk("a_fs", fs, exp_fs);
        chk("a_ready", r, exp_rdy);
        chk("c_overflow", 256'(overflow), 256'(1));
        chk("b_latch_ready", 256'(bus.shft_ready), 256'(1));

        // Frame B
        run_frame(-1, '0, -1, '0, -1, d, s, fs, r);
        chk("b_data", d, {WB, 180'b0});
        chk("b_sync", s, exp_sync);
        chk("b_fs", fs, exp_fs);
        chk("b_ready", r, {256{1'b1}});
        chk("ovf_sticky", 256'(overflow), 256'(1));

        // Underrun frame, enable dropped at bit 100
`ifdef AC97_TX_UNDERRUN_REPEAT_EN
        exp_under = {WB, 180'b0};
`else
        exp_under = '0;
`endif
        run_frame(-1, '0, -1, '0, 100, d, s, fs, r);
        chk("under_data", d, exp_under);
        chk("under_sync", s, exp_sync);
        chk("under_fs", fs, exp_fs);
        chk("under_ready", r, {256{1'b1}});
        chk("idle_sync", 256'(sync), 256'(0));
        chk("idle_sdata", 256'(sdata_out), 256'(0));
        chk("idle_fs", 256'(frame_start), 256'(0));
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (frame_start || sync || sdata_out) seen = 1'b1;
            tick();
        end
        chk("idle_quiet", 256'(seen), 256'(0));

        // Mid-frame reset with holding register full
        bus.shft_data = WD;
        bus.shft_load = 1'b1;
        tick();
        bus.shft_load = 1'b0;
        en = 1'b1;
        tick();
        for (int n = 0; n < 40; n++) begin
            bus.shft_load = (n == 5);
            if (n == 5) bus.shft_data = WE;
            tick();
        end
        bus.shft_load = 1'b0;
        chk("pre_rst_ready", 256'(bus.shft_ready), 256'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 256'(bus.shft_ready), 256'(1));
        chk("mid_rst_sync", 256'(sync), 256'(0));
        chk("mid_rst_sdata", 256'(sdata_out), 256'(0));
        chk("mid_rst_fs", 256'(frame_start), 256'(0));
        chk("mid_rst_ovf", 256'(overflow), 256'(0));
        rst_n = 1'b1;
        tick();
        run_frame(-1, '0, -1, '0, -1, d, s, fs, r);
        chk("post_rst_data", d, 256'b0);
        chk("post_rst_sync", s, exp_sync);
        chk("post_rst_fs", fs, exp_fs);
        chk("post_rst_ready", r, {256{1'b1}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
